// File: rtl/dac_spi_receiver.sv
// Receive end of the DAC serial port: samples SYNC/SCLK/DIN on dataclk and rebuilds each frame.
// It emits the 16-bit code and the power-down bits as a one-cycle valid word.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a registered SYNC falling edge while rx_en is high
// SHIFT      | taking DIN on each SCLK fall; an early SYNC rise aborts the frame
// WAIT_HIGH  | frame complete; extra SCLK edges are ignored until SYNC goes high
module dac_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 24
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        rx_en,
    input  logic        DAC_SYNC,
    input  logic        DAC_SCLK,
    input  logic        DAC_DIN,
    output logic [15:0] word_out,
    output logic [1:0]  pd_mode,
    output logic        word_valid,
    output logic        frame_error,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SHIFT     = 2'd1;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd2;

    localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] din_pipe;
    logic                   sync_prev;
    logic                   sclk_prev;

    logic [1:0]             state;
    logic [4:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shift_reg;

    logic                   sync_cur;
    logic                   sclk_cur;
    logic                   din_cur;
    logic                   sync_fall;
    logic                   sclk_fall;
    logic [FRAME_BITS-1:0]  shift_next;

    assign sync_cur   = sync_pipe[SYNC_STAGES-1];
    assign sclk_cur   = sclk_pipe[SYNC_STAGES-1];
    assign din_cur    = din_pipe[SYNC_STAGES-1];
    assign sync_fall  = sync_prev & ~sync_cur;
    assign sclk_fall  = sclk_prev & ~sclk_cur;
    assign shift_next = {shift_reg[FRAME_BITS-2:0], din_cur};
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge dataclk) begin
        if (reset) begin
            // Pins reset high so the first real low level is the only thing that can look like an edge.
            sync_pipe   <= '1;
            sclk_pipe   <= '1;
            din_pipe    <= '1;
            sync_prev   <= 1'b1;
            sclk_prev   <= 1'b1;
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            word_out    <= '0;
            pd_mode     <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            sync_pipe[0] <= DAC_SYNC;
            sclk_pipe[0] <= DAC_SCLK;
            din_pipe[0]  <= DAC_DIN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
                sclk_pipe[i] <= sclk_pipe[i-1];
                din_pipe[i]  <= din_pipe[i-1];
            end
            sync_prev   <= sync_cur;
            sclk_prev   <= sclk_cur;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;

            if (!rx_en) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sync_fall) begin
                            state     <= ST_SHIFT;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        // A SYNC rise wins over a coincident SCLK fall.
                        if (sync_cur) begin
                            frame_error <= 1'b1;
                            state       <= ST_IDLE;
                        end else if (sclk_fall) begin
                            shift_reg <= shift_next;
                            if (bit_cnt == CNT_LAST) begin
                                bit_cnt     <= CNT_FULL;
                                word_out    <= shift_next[15:0];
                                pd_mode     <= shift_next[17:16];
                                word_valid  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                state       <= ST_WAIT_HIGH;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (sync_cur) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: table of serial frames plus hand-written reset and wrap sequences.
// Expected words are queued when a frame is driven and matched against words the monitor captures.
module tb_dac_spi_receiver;

    logic        dataclk = 1'b0;
    logic        reset;
    logic        rx_en;
    logic        DAC_SYNC;
    logic        DAC_SCLK;
    logic        DAC_DIN;
    logic [15:0] word_out;
    logic [1:0]  pd_mode;
    logic        word_valid;
    logic        frame_error;
    logic        busy;
    logic [15:0] frame_count;

    dac_spi_receiver #(.SYNC_STAGES(2), .FRAME_BITS(24)) dut (
        .dataclk     (dataclk),
        .reset       (reset),
        .rx_en       (rx_en),
        .DAC_SYNC    (DAC_SYNC),
        .DAC_SCLK    (DAC_SCLK),
        .DAC_DIN     (DAC_DIN),
        .word_out    (word_out),
        .pd_mode     (pd_mode),
        .word_valid  (word_valid),
        .frame_error (frame_error),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 dataclk = ~dataclk;

    typedef struct {
        logic [23:0] frame;
        int          nfalls;
        int          ph;
        int          gap;
        bit          en;
        bit          chk;
        bit          exp_valid;
        bit          exp_err;
        logic [15:0] exp_word;
        logic [1:0]  exp_pd;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic [1:0]  pd;
        logic [15:0] count;
        int          cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];

    int cyc = 0;
    int err_seen = 0;
    int both_seen = 0;
    int last_fall_cyc = 0;
    int total = 0;
    int bad = 0;
    logic [15:0] exp_count;
    logic [15:0] last_word;
    logic [1:0]  last_pd;
    int exp_err_total;

    always @(posedge dataclk) cyc <= cyc + 1;

    always @(negedge dataclk) begin
        if (!reset) begin
            if (word_valid) obs_q.push_back('{word_out, pd_mode, frame_count, cyc});
            if (frame_error) err_seen = err_seen + 1;
            if (word_valid && frame_error) both_seen = both_seen + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send_frame(input logic [23:0] fr, input int nfalls, input int ph);
        @(negedge dataclk);
        DAC_SYNC = 1'b0;
        DAC_SCLK = 1'b1;
        for (int i = 0; i < nfalls; i++) begin
            DAC_DIN = (i < 24) ? fr[23-i] : 1'($urandom);
            repeat (ph) @(negedge dataclk);
            DAC_SCLK = 1'b0;
            if (i == 23) last_fall_cyc = cyc;
            repeat (ph) @(negedge dataclk);
            DAC_SCLK = 1'b1;
        end
        repeat (ph) @(negedge dataclk);
        DAC_SYNC = 1'b1;
    endtask

    task automatic expect_word(input logic [15:0] w, input logic [1:0] p);
        exp_count = exp_count + 16'd1;
        exp_q.push_back('{w, p, exp_count, 0});
        last_word = w;
        last_pd   = p;
    endtask

    task automatic drain(input string tag, input bit chk_lat);
        rec_t e;
        rec_t o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_word"},  int'(o.word),  int'(e.word));
            check({tag, "_pd"},    int'(o.pd),    int'(e.pd));
            check({tag, "_count"}, int'(o.count), int'(e.count));
            if (chk_lat) check({tag, "_latency"}, o.cyc - last_fall_cyc, 3);
        end
        check({tag, "_missing_valid"}, exp_q.size(), 0);
        check({tag, "_extra_valid"},   obs_q.size(), 0);
        check({tag, "_frame_errors"},  err_seen, exp_err_total);
        check({tag, "_word_hold"},     int'(word_out), int'(last_word));
        check({tag, "_pd_hold"},       int'(pd_mode),  int'(last_pd));
        check({tag, "_frame_count"},   int'(frame_count), int'(exp_count));
        check({tag, "_busy"},          int'(busy), 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{24'h008000, 24, 4, 3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 2'd0};
        vecs[1] = '{24'h03ABCD, 24, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hABCD, 2'd3};
        vecs[2] = '{24'h3F1234, 24, 2, 4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 2'd3};
        vecs[3] = '{24'h0A9999, 10, 3, 4, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 2'd0};
        vecs[4] = '{24'h005555, 24, 3, 4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 2'd0};
        vecs[5] = '{24'h02C3A5, 27, 2, 4, 1'b1, 1'b1, 1'b1, 1'b0, 16'hC3A5, 2'd2};
        vecs[6] = '{24'h017777, 24, 2, 4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0};

        reset = 1'b1; rx_en = 1'b1;
        DAC_SYNC = 1'b1; DAC_SCLK = 1'b1; DAC_DIN = 1'b0;
        exp_count = 16'd0; last_word = 16'd0; last_pd = 2'd0; exp_err_total = 0;
        repeat (3) @(negedge dataclk);
        reset = 1'b0;

        repeat (20) @(negedge dataclk);
        check("idle_word",        int'(word_out), 0);
        check("idle_pd",          int'(pd_mode), 0);
        check("idle_busy",        int'(busy), 0);
        check("idle_count",       int'(frame_count), 0);
        check("idle_valid_seen",  obs_q.size(), 0);
        check("idle_error_seen",  err_seen, 0);

        for (int v = 0; v < 7; v++) begin
            rx_en = vecs[v].en;
            if (vecs[v].exp_valid) expect_word(vecs[v].exp_word, vecs[v].exp_pd);
            if (vecs[v].exp_err) exp_err_total++;
            send_frame(vecs[v].frame, vecs[v].nfalls, vecs[v].ph);
            repeat (vecs[v].gap) @(negedge dataclk);
            if (vecs[v].chk) begin
                repeat (8) @(negedge dataclk);
                drain($sformatf("vec%0d", v), v == 0);
            end
            rx_en = 1'b1;
        end

        // Reset in the middle of a frame: partial frame dropped, no abort pulse.
        @(negedge dataclk);
        DAC_SYNC = 1'b0;
        for (int i = 0; i < 12; i++) begin
            DAC_DIN = 1'b1;
            repeat (2) @(negedge dataclk);
            DAC_SCLK = 1'b0;
            repeat (2) @(negedge dataclk);
            DAC_SCLK = 1'b1;
        end
        check("midreset_busy_before", int'(busy), 1);
        reset = 1'b1; DAC_SYNC = 1'b1; DAC_SCLK = 1'b1;
        repeat (3) @(negedge dataclk);
        reset = 1'b0;
        exp_count = 16'd0; last_word = 16'd0; last_pd = 2'd0;
        repeat (10) @(negedge dataclk);
        drain("midreset", 1'b0);

        // Counter wrap from 0xFFFF.
        @(negedge dataclk);
        force dut.frame_count = 16'hFFFF;
        @(negedge dataclk);
        release dut.frame_count;
        exp_count = 16'hFFFF;
        expect_word(16'h0F0F, 2'd1);
        send_frame(24'h010F0F, 24, 2);
        repeat (10) @(negedge dataclk);
        drain("wrap", 1'b0);
        check("wrap_count_zero", int'(frame_count), 0);

        check("valid_and_error_together", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
